// File: rtl/line_buffer_3x3_if.sv
`default_nettype none
// ============================================================================
// Module      : line_buffer_3x3_if
// Description : Pixel-in / 3x3-window-out bundle between a pixel source and
//               the line buffer; no backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
interface line_buffer_3x3_if;
    logic       in_valid;
    logic [7:0] in_pixel;
    logic       out_valid;
    logic       frame_done;
    logic [7:0] win00, win01, win02;
    logic [7:0] win10, win11, win12;
    logic [7:0] win20, win21, win22;

    modport master (
        output in_valid, in_pixel,
        input  out_valid, frame_done,
        input  win00, win01, win02, win10, win11, win12, win20, win21, win22
    );

    modport slave (
        input  in_valid, in_pixel,
        output out_valid, frame_done,
        output win00, win01, win02, win10, win11, win12, win20, win21, win22
    );
endinterface
`default_nettype wire

// File: rtl/line_buffer_3x3.sv
`default_nettype none
// ============================================================================
// Module      : line_buffer_3x3
// Description : Raster line buffer and 3x3 valid-padding window generator.
//               Optional macro LINEBUF_STRIDE2_EN: emit stride-2 windows only.
// Revision    : 1.0 - initial release
// ============================================================================
module line_buffer_3x3 #(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28
) (
    input  logic             clk,
    input  logic             rst_n,
    line_buffer_3x3_if.slave bus
);
    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);
`ifdef LINEBUF_STRIDE2_EN
    localparam int LAST_ROW = ((IMG_H - 1) / 2) * 2;
    localparam int LAST_COL = ((IMG_W - 1) / 2) * 2;
`else
    localparam int LAST_ROW = IMG_H - 1;
    localparam int LAST_COL = IMG_W - 1;
`endif

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [7:0]       lb0 [IMG_W];
    logic [7:0]       lb1 [IMG_W];
    logic [7:0]       t0;
    logic [7:0]       t1;
    logic             last_col;
    logic             last_row;
    logic             emit;
    logic             at_last;

    always_comb begin
        t0       = lb0[col];
        t1       = lb1[col];
        last_col = (col == COL_W'(IMG_W - 1));
        last_row = (row == ROW_W'(IMG_H - 1));
        // Valid padding: the whole 3x3 footprint must lie inside the current frame.
        emit     = (row >= ROW_W'(2)) && (col >= COL_W'(2));
`ifdef LINEBUF_STRIDE2_EN
        emit     = emit && !row[0] && !col[0];
`endif
        at_last  = (row == ROW_W'(LAST_ROW)) && (col == COL_W'(LAST_COL));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (bus.in_valid) begin
            if (last_col) begin
                col <= '0;
                row <= last_row ? '0 : row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (bus.in_valid) begin
            lb0[col] <= t1;
            lb1[col] <= bus.in_pixel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid  <= 1'b0;
            bus.frame_done <= 1'b0;
            bus.win00 <= '0; bus.win01 <= '0; bus.win02 <= '0;
            bus.win10 <= '0; bus.win11 <= '0; bus.win12 <= '0;
            bus.win20 <= '0; bus.win21 <= '0; bus.win22 <= '0;
        end else begin
            bus.out_valid  <= bus.in_valid && emit;
            bus.frame_done <= bus.in_valid && emit && at_last;
            if (bus.in_valid) begin
                bus.win00 <= bus.win01; bus.win01 <= bus.win02; bus.win02 <= t0;
                bus.win10 <= bus.win11; bus.win11 <= bus.win12; bus.win12 <= t1;
                bus.win20 <= bus.win21; bus.win21 <= bus.win22; bus.win22 <= bus.in_pixel;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_line_buffer_3x3.sv
`default_nettype none
// ============================================================================
// Module      : tb_line_buffer_3x3
// Description : Scoreboard bench for line_buffer_3x3 (5x4 directed + 28x28).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_line_buffer_3x3;
    localparam int SW = 5;
    localparam int SH = 4;
    localparam int BW = 28;
    localparam int BH = 28;
`ifdef LINEBUF_STRIDE2_EN
    localparam bit STRIDE2 = 1'b1;
    localparam int N_S = 2;
    localparam int N_B = 169;
    localparam logic [72:0] LAST_S = {1'b1, 8'd2, 8'd3, 8'd4, 8'd7, 8'd8, 8'd9, 8'd12, 8'd13, 8'd14};
`else
    localparam bit STRIDE2 = 1'b0;
    localparam int N_S = 6;
    localparam int N_B = 676;
    localparam logic [72:0] LAST_S = {1'b1, 8'd7, 8'd8, 8'd9, 8'd12, 8'd13, 8'd14, 8'd17, 8'd18, 8'd19};
`endif
    localparam logic [72:0] FIRST_S  = {1'b0, 8'd0, 8'd1, 8'd2, 8'd5, 8'd6, 8'd7, 8'd10, 8'd11, 8'd12};
    localparam logic [72:0] FIRST_S2 = {1'b0, 8'd100, 8'd101, 8'd102, 8'd105, 8'd106, 8'd107,
                                        8'd110, 8'd111, 8'd112};

    typedef struct packed {
        logic [31:0] cyc;
        logic        fd;
        logic [71:0] win;
    } exp_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] cyc   = '0;
    int          n_checks = 0;
    int          n_fail   = 0;

    line_buffer_3x3_if bus_s();
    line_buffer_3x3_if bus_b();

    line_buffer_3x3 #(.IMG_W(SW), .IMG_H(SH)) dut_s (.clk(clk), .rst_n(rst_n), .bus(bus_s));
    line_buffer_3x3 #(.IMG_W(BW), .IMG_H(BH)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 32'd1;

    logic [71:0] win_s, win_b;
    assign win_s = {bus_s.win00, bus_s.win01, bus_s.win02, bus_s.win10, bus_s.win11,
                    bus_s.win12, bus_s.win20, bus_s.win21, bus_s.win22};
    assign win_b = {bus_b.win00, bus_b.win01, bus_b.win02, bus_b.win10, bus_b.win11,
                    bus_b.win12, bus_b.win20, bus_b.win21, bus_b.win22};

    logic [7:0]  img_s [SH][SW];
    logic [7:0]  img_b [BH][BW];
    int          mr_s = 0, mc_s = 0, mr_b = 0, mc_b = 0;
    exp_t        q_s[$];
    exp_t        q_b[$];
    logic [72:0] log_s[$];
    int          n_win_b = 0, n_fd_b = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit emits(input int r, input int c);
        return (r >= 2) && (c >= 2) && (!STRIDE2 || ((r % 2 == 0) && (c % 2 == 0)));
    endfunction

    function automatic bit lasts(input int r, input int c, input int w, input int h);
        if (STRIDE2) return (r == ((h - 1) / 2) * 2) && (c == ((w - 1) / 2) * 2);
        return (r == h - 1) && (c == w - 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send_s(input logic [7:0] p);
        exp_t e;
        bus_s.in_valid = 1'b1;
        bus_s.in_pixel = p;
        img_s[mr_s][mc_s] = p;
        if (emits(mr_s, mc_s)) begin
            e.win = '0;
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    e.win = {e.win[63:0], img_s[mr_s-2+i][mc_s-2+j]};
            e.cyc = cyc + 32'd1;
            e.fd  = lasts(mr_s, mc_s, SW, SH);
            q_s.push_back(e);
        end
        if (mc_s == SW - 1) begin
            mc_s = 0;
            mr_s = (mr_s == SH - 1) ? 0 : mr_s + 1;
        end else begin
            mc_s++;
        end
        tick();
        bus_s.in_valid = 1'b0;
        bus_s.in_pixel = 8'($urandom);
    endtask

    task automatic send_b(input logic [7:0] p);
        exp_t e;
        bus_b.in_valid = 1'b1;
        bus_b.in_pixel = p;
        img_b[mr_b][mc_b] = p;
        if (emits(mr_b, mc_b)) begin
            e.win = '0;
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    e.win = {e.win[63:0], img_b[mr_b-2+i][mc_b-2+j]};
            e.cyc = cyc + 32'd1;
            e.fd  = lasts(mr_b, mc_b, BW, BH);
            q_b.push_back(e);
        end
        if (mc_b == BW - 1) begin
            mc_b = 0;
            mr_b = (mr_b == BH - 1) ? 0 : mr_b + 1;
        end else begin
            mc_b++;
        end
        tick();
        bus_b.in_valid = 1'b0;
    endtask

    task automatic frame_s(input int base, input bit gaps);
        for (int k = 0; k < SW * SH; k++) begin
            send_s(8'(base + k));
            if (gaps) idle($urandom_range(0, 3));
        end
    endtask

    task automatic check_log(input string tag, input int frames);
        int nfd = 0;
        foreach (log_s[k]) nfd += int'(log_s[k][72]);
        check({tag, "_count"}, 128'(log_s.size()), 128'(N_S * frames));
        check({tag, "_first"}, 128'(log_s[0]), 128'(FIRST_S));
        check({tag, "_last"}, 128'(log_s[log_s.size()-1]), 128'(LAST_S));
        check({tag, "_fd_count"}, 128'(nfd), 128'(frames));
    endtask

    // Small-DUT monitor: scoreboard pops plus gap-cycle stability.
    logic        acc_s;
    logic [71:0] prev_s;
    always @(posedge clk) acc_s <= bus_s.in_valid;
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (bus_s.out_valid) begin
                if (q_s.size() == 0) begin
                    check("window_s_unexpected", {bus_s.out_valid, win_s}, 128'd0);
                end else begin
                    e = q_s.pop_front();
                    check("window_s", {cyc, bus_s.frame_done, win_s}, e);
                end
                log_s.push_back({bus_s.frame_done, win_s});
            end
            if (!acc_s)
                check("gap_s", {bus_s.out_valid, bus_s.frame_done, win_s}, {2'b00, prev_s});
        end
        prev_s <= win_s;
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus_b.out_valid) begin
            n_win_b++;
            n_fd_b += int'(bus_b.frame_done);
            if (q_b.size() == 0) begin
                check("window_b_unexpected", {bus_b.out_valid, win_b}, 128'd0);
            end else begin
                e = q_b.pop_front();
                check("window_b", {cyc, bus_b.frame_done, win_b}, e);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_s.in_valid = 1'b0;
        bus_s.in_pixel = '0;
        bus_b.in_valid = 1'b0;
        bus_b.in_pixel = '0;
        idle(3);
        check("reset_s", {bus_s.out_valid, bus_s.frame_done, win_s}, 128'd0);
        check("reset_b", {bus_b.out_valid, bus_b.frame_done, win_b}, 128'd0);
        rst_n = 1'b1;
        tick();

        log_s.delete();
        frame_s(0, 1'b0);
        idle(3);
        check_log("stream", 1);

        log_s.delete();
        frame_s(0, 1'b1);
        idle(3);
        check_log("gaps", 1);

        log_s.delete();
        frame_s(0, 1'b0);
        frame_s(100, 1'b0);
        idle(3);
        check("two_frames_count", 128'(log_s.size()), 128'(2 * N_S));
        check("two_frames_first2", 128'(log_s[N_S]), 128'(FIRST_S2));
        check("two_frames_last1", 128'(log_s[N_S-1]), 128'(LAST_S));

        for (int k = 0; k < 14; k++) send_s(8'(k));
        idle(1);
        check("pre_reset_queue", 128'(q_s.size()), 128'd0);
        rst_n = 1'b0;
        mr_s = 0; mc_s = 0;
        #1;
        check("async_reset_s", {bus_s.out_valid, bus_s.frame_done, win_s}, 128'd0);
        tick();
        rst_n = 1'b1;
        tick();
        log_s.delete();
        frame_s(0, 1'b0);
        idle(3);
        check_log("after_reset", 1);

        for (int k = 0; k < BW * BH; k++) send_b(8'($urandom));
        idle(3);
        check("big_windows", 128'(n_win_b), 128'(N_B));
        check("big_frame_done", 128'(n_fd_b), 128'd1);

        check("queue_s_empty", 128'(q_s.size()), 128'd0);
        check("queue_b_empty", 128'(q_b.size()), 128'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
